// File: rtl/wide_add_seq.sv
// Byte-serial WIDTH-bit adder: one shared 8-bit adder slice, carry chained through a register.
// Optional build macro ADD_SUB_EN adds a sub input (a - b) and a signed-overflow output ovf.
module wide_add_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              busy_q, busy_d;
`ifdef ADD_SUB_EN
    logic              sub_q, sub_d;
    logic              ovf_q, ovf_d;
    logic              slice_c7;
`endif

    logic [7:0] slice_a;
    logic [7:0] slice_b;
    logic [7:0] slice_s;
    logic       slice_co;

    // The single shared 8-bit adder slice, fed from the byte selected by idx_q.
    always_comb begin : adder_8bit
        slice_a = a_q[8*idx_q +: 8];
        slice_b = b_q[8*idx_q +: 8];
`ifdef ADD_SUB_EN
        if (sub_q) begin
            slice_b = ~slice_b;
        end
`endif
        {slice_co, slice_s} = 9'({1'b0, slice_a}) + 9'({1'b0, slice_b}) + 9'(carry_q);
`ifdef ADD_SUB_EN
        slice_c7 = slice_a[7] ^ slice_b[7] ^ slice_s[7];
`endif
    end

    always_comb begin : next_state
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef ADD_SUB_EN
        sub_d   = sub_q;
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = cin;
`ifdef ADD_SUB_EN
                    sub_d   = sub;
                    // Subtract is a + ~b + 1; cin plays no part.
                    if (sub) begin
                        carry_d = 1'b1;
                    end
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[8*idx_q +: 8] = slice_s;
                carry_d             = slice_co;
                idx_d               = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_co;
`ifdef ADD_SUB_EN
                    ovf_d   = slice_c7 ^ slice_co;
`endif
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake flags follow the next state so they are registered with it.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ADD_SUB_EN
            sub_q       <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            busy_q      <= busy_d;
`ifdef ADD_SUB_EN
            sub_q       <= sub_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;
`ifdef ADD_SUB_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed self-checking bench for wide_add_seq at WIDTH=32 (sub/ovf cases when ADD_SUB_EN is defined).
module tb_wide_add_seq;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned NBYTES     = WIDTH / 8;
    // accept edge, NBYTES RUN cycles, one DONE cycle, one IDLE cycle
    localparam int unsigned ACCEPT_GAP = NBYTES + 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef ADD_SUB_EN
    logic             sub;
    logic             ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    wide_add_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and return the edge count at which it was accepted.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tc,
                        output int k);
        int n = 0;
        a        = ta;
        b        = tb;
        cin      = tc;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check_val("send_ready", 64'(in_ready), 64'd1);
        step();
        k        = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int t);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
        t = cyc;
    endtask

    // Complete the output handshake and confirm the return to IDLE.
    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        check_val({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int k;
        int t;
        int acc[$];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef ADD_SUB_EN
        sub       = 1'b0;
`endif
        repeat (2) step();
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_sum", 64'(sum), 64'd0);
        check_val("rst_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        step();

        // 1: full carry ripple, latency NBYTES
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, k);
        check_val("t1_busy", 64'(busy), 64'd1);
        check_val("t1_in_ready", 64'(in_ready), 64'd0);
        wait_valid("t1", t);
        check_val("t1_latency", 64'(t - k), 64'(NBYTES));
        check_val("t1_sum", 64'(sum), 64'h0000_0000);
        check_val("t1_cout", 64'(cout), 64'd1);
        release_result("t1");

        // 2: stall on out_ready, result must hold
        send(32'h1234_5678, 32'h1111_1111, 1'b1, k);
        wait_valid("t2", t);
        for (int i = 0; i < 10; i++) begin
            check_val("t2_hold_sum", 64'(sum), 64'h2345_678A);
            check_val("t2_hold_cout", 64'(cout), 64'd0);
            check_val("t2_hold_valid", 64'(out_valid), 64'd1);
            check_val("t2_hold_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        release_result("t2");

        // 3: operand changes and in_valid during RUN/DONE are ignored
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, k);
        a        = 32'hFFFF_FFFF;
        b        = 32'hFFFF_FFFF;
        cin      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < int'(NBYTES) + 3; i++) begin
            check_val("t3_in_ready", 64'(in_ready), 64'd0);
            check_val("t3_busy", 64'(busy), 64'd1);
            step();
        end
        check_val("t3_sum", 64'(sum), 64'h0000_0100);
        check_val("t3_cout", 64'(cout), 64'd0);
        in_valid = 1'b0;
        release_result("t3");
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, k);
        wait_valid("t3b", t);
        check_val("t3b_sum", 64'(sum), 64'hFFFF_FFFE);
        check_val("t3b_cout", 64'(cout), 64'd1);
        release_result("t3b");

        // 4: synchronous reset while byte 2 is in the adder
        send(32'h0101_0101, 32'h0202_0202, 1'b0, k);
        repeat (2) step();
        rst_n = 1'b0;
        step();
        check_val("t4_out_valid", 64'(out_valid), 64'd0);
        check_val("t4_in_ready", 64'(in_ready), 64'd1);
        check_val("t4_sum", 64'(sum), 64'd0);
        check_val("t4_cout", 64'(cout), 64'd0);
        check_val("t4_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        step();
        send(32'h89AB_CDEF, 32'h7654_3210, 1'b1, k);
        wait_valid("t4b", t);
        check_val("t4b_sum", 64'(sum), 64'h0000_0000);
        check_val("t4b_cout", 64'(cout), 64'd1);
        release_result("t4b");

        // 5: back-to-back with out_ready held high
        a         = 32'h0000_0010;
        b         = 32'h0000_0020;
        cin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && acc.size() < 3; i++) begin
            if (in_valid && in_ready) acc.push_back(cyc + 1);
            if (out_valid) check_val("t5_sum", 64'(sum), 64'h0000_0030);
            step();
        end
        in_valid = 1'b0;
        check_val("t5_accepts", 64'(acc.size()), 64'd3);
        if (acc.size() == 3) begin
            check_val("t5_gap1", 64'(acc[1] - acc[0]), 64'(ACCEPT_GAP));
            check_val("t5_gap2", 64'(acc[2] - acc[1]), 64'(ACCEPT_GAP));
        end
        out_ready = 1'b0;
        wait_valid("t5_last", t);
        check_val("t5_last_sum", 64'(sum), 64'h0000_0030);
        release_result("t5");

`ifdef ADD_SUB_EN
        // 6: subtract mode, borrow and signed overflow
        sub = 1'b1;
        send(32'h0000_0005, 32'h0000_0007, 1'b0, k);
        wait_valid("t6a", t);
        check_val("t6a_sum", 64'(sum), 64'hFFFF_FFFE);
        check_val("t6a_cout", 64'(cout), 64'd0);
        check_val("t6a_ovf", 64'(ovf), 64'd0);
        release_result("t6a");
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, k);
        wait_valid("t6b", t);
        check_val("t6b_sum", 64'(sum), 64'h8000_0000);
        check_val("t6b_cout", 64'(cout), 64'd0);
        check_val("t6b_ovf", 64'(ovf), 64'd1);
        release_result("t6b");
        sub = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
